// File: rtl/lfsr_pkg.sv
// Shared types and the maximal-length tap table for the LFSR stream generator.
package lfsr_pkg;

    typedef enum logic {
        LFSR_FIB = 1'b0,
        LFSR_GAL = 1'b1
    } lfsr_mode_e;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_HOLD = 1'b1
    } lfsr_fsm_e;

    localparam int LFSR_MIN_W = 3;
    localparam int LFSR_MAX_W = 32;

    // Bit k-1 set for tap k of the primitive polynomial; the MSB is always a tap.
    function automatic logic [31:0] lfsr_taps(input int width);
        logic [31:0] taps;
        case (width)
            3:       taps = 32'h0000_0006;
            4:       taps = 32'h0000_000C;
            5:       taps = 32'h0000_0014;
            6:       taps = 32'h0000_0030;
            7:       taps = 32'h0000_0060;
            8:       taps = 32'h0000_00B8;
            9:       taps = 32'h0000_0110;
            10:      taps = 32'h0000_0240;
            11:      taps = 32'h0000_0500;
            12:      taps = 32'h0000_0829;
            13:      taps = 32'h0000_100D;
            14:      taps = 32'h0000_2015;
            15:      taps = 32'h0000_6000;
            16:      taps = 32'h0000_D008;
            17:      taps = 32'h0001_2000;
            18:      taps = 32'h0002_0400;
            19:      taps = 32'h0004_0023;
            20:      taps = 32'h0009_0000;
            21:      taps = 32'h0014_0000;
            22:      taps = 32'h0030_0000;
            23:      taps = 32'h0042_0000;
            24:      taps = 32'h00E1_0000;
            25:      taps = 32'h0120_0000;
            26:      taps = 32'h0200_0023;
            27:      taps = 32'h0400_0013;
            28:      taps = 32'h0900_0000;
            29:      taps = 32'h1400_0000;
            30:      taps = 32'h2000_0029;
            31:      taps = 32'h4800_0000;
            32:      taps = 32'h8020_0003;
            default: taps = 32'h0000_0000;
        endcase
        return taps;
    endfunction

endpackage

// File: rtl/lfsr_step.sv
// One combinational LFSR step in either Fibonacci or Galois form.
module lfsr_step
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(lfsr_taps(WIDTH))
) (
    input  logic [WIDTH-1:0] s,
    input  logic             mode,
    output logic [WIDTH-1:0] s_next,
    output logic             out_bit
);

    always_comb begin
        s_next  = s;
        out_bit = 1'b0;
        if (lfsr_mode_e'(mode) == LFSR_GAL) begin
            out_bit = s[0];
            s_next  = (s >> 1) ^ (s[0] ? TAPS : '0);
        end else begin
            out_bit = s[WIDTH-1];
            s_next  = {s[WIDTH-2:0], ^(s & TAPS)};
        end
    end

endmodule

// File: rtl/lfsr_stream.sv
// Pseudo-random word source: steps the LFSR OUT_W times per word, then holds
// the word on a valid/ready port until it is consumed.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   ST_FILL | LFSR steps every cycle, one bit shifted into the word
//   ST_HOLD | word complete, LFSR frozen, waiting for out_ready
module lfsr_stream
    import lfsr_pkg::*;
#(
    parameter int               WIDTH      = 8,
    parameter int               OUT_W      = 8,
    parameter logic [WIDTH-1:0] RESET_SEED = WIDTH'(1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             seed_we,
    input  logic [WIDTH-1:0] seed,
    input  logic             mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [WIDTH-1:0] state,
    output logic             seed_err
);

    localparam int               CNT_W    = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(OUT_W - 1);
    localparam logic [WIDTH-1:0] TAPS     = WIDTH'(lfsr_taps(WIDTH));

    generate
        if (WIDTH < LFSR_MIN_W || WIDTH > LFSR_MAX_W) begin : g_bad_width
            $error("lfsr_stream: WIDTH must be within 3..32");
        end
        if (OUT_W < 1 || OUT_W > WIDTH) begin : g_bad_out_w
            $error("lfsr_stream: OUT_W must be within 1..WIDTH");
        end
        if (RESET_SEED == '0) begin : g_bad_seed
            $error("lfsr_stream: RESET_SEED must be non-zero");
        end
    endgenerate

    lfsr_fsm_e        fsm_q, fsm_d;
    lfsr_mode_e       mode_q, mode_d;
    logic [WIDTH-1:0] state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [OUT_W-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;

    logic [WIDTH-1:0] step_next;
    logic             step_bit;

    lfsr_step #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS)
    ) u_step (
        .s       (state_q),
        .mode    (mode_q),
        .s_next  (step_next),
        .out_bit (step_bit)
    );

    // cnt_q counts remaining steps down; the word completes on the step taken at zero.
    always_comb begin
        fsm_d   = fsm_q;
        mode_d  = mode_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        valid_d = valid_q;
        err_d   = 1'b0;

        if (seed_we) begin
            state_d = (seed == '0) ? RESET_SEED : seed;
            err_d   = (seed == '0);
            mode_d  = lfsr_mode_e'(mode);
            cnt_d   = CNT_LOAD;
            data_d  = '0;
            valid_d = 1'b0;
            fsm_d   = ST_FILL;
        end else begin
            case (fsm_q)
                ST_FILL: begin
                    state_d = step_next;
                    data_d  = (data_q << 1) | OUT_W'(step_bit);
                    if (cnt_q == '0) begin
                        valid_d = 1'b1;
                        fsm_d   = ST_HOLD;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        valid_d = 1'b0;
                        cnt_d   = CNT_LOAD;
                        fsm_d   = ST_FILL;
                    end
                end
                default: fsm_d = ST_FILL;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q   <= ST_FILL;
            mode_q  <= LFSR_FIB;
            state_q <= RESET_SEED;
            cnt_q   <= CNT_LOAD;
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            mode_q  <= mode_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign state     = state_q;
    assign seed_err  = err_q;

endmodule

// File: tb/tb_lfsr_stream.sv
// Self-checking bench for lfsr_stream (WIDTH=8, OUT_W=8): vector table,
// hand-written corner sequences and a randomized run against a word-level model.
module tb_lfsr_stream;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       seed_we = 1'b0;
    logic [7:0] seed = 8'h00;
    logic       mode = 1'b0;
    logic       out_ready = 1'b0;
    logic       out_valid;
    logic [7:0] out_data;
    logic [7:0] state;
    logic       seed_err;

    lfsr_stream #(
        .WIDTH      (8),
        .OUT_W      (8),
        .RESET_SEED (8'h01)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .seed_we   (seed_we),
        .seed      (seed),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .state     (state),
        .seed_err  (seed_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] m_s;
    bit         m_gal;

    typedef struct {
        logic [7:0] sd;
        bit         gal;
        bit         err;
        logic [7:0] word;
        logic [7:0] st;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Reference model: plain arithmetic on the integer value of the state.
    function automatic logic [7:0] m_next(input logic [7:0] s, input bit gal);
        int v;
        v = int'(s);
        if (gal) begin
            if (v % 2 == 1) return 8'((v / 2) ^ 'hB8);
            return 8'(v / 2);
        end
        return 8'(((v * 2) % 256) + ($countones(s & 8'hB8) % 2));
    endfunction

    function automatic int m_bit(input logic [7:0] s, input bit gal);
        int v;
        v = int'(s);
        return gal ? (v % 2) : (v / 128);
    endfunction

    task automatic m_load(input logic [7:0] sd, input bit gal);
        m_s   = (sd == 8'h00) ? 8'h01 : sd;
        m_gal = gal;
    endtask

    task automatic m_word(output logic [7:0] w);
        int acc;
        acc = 0;
        for (int i = 0; i < 8; i++) begin
            acc = acc * 2 + m_bit(m_s, m_gal);
            m_s = m_next(m_s, m_gal);
        end
        w = 8'(acc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_seed(input logic [7:0] sd, input bit md);
        seed_we = 1'b1;
        seed    = sd;
        mode    = md;
        tick();
        seed_we = 1'b0;
        m_load(sd, md);
    endtask

    task automatic wait_valid(output int cyc);
        cyc = -1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (out_valid) begin
                cyc = i;
                break;
            end
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int         cyc;
        int         bad;
        int         steps;
        int         k;
        logic [7:0] w, w2, prev, d_hold, s_hold, exp_st, sd;
        bit         md;

        vecs[0] = '{sd: 8'h01, gal: 1'b0, err: 1'b0, word: 8'h01, st: 8'h1C};
        vecs[1] = '{sd: 8'h01, gal: 1'b1, err: 1'b0, word: 8'h8E, st: 8'h64};
        vecs[2] = '{sd: 8'h00, gal: 1'b0, err: 1'b1, word: 8'h01, st: 8'h1C};
        vecs[3] = '{sd: 8'h00, gal: 1'b1, err: 1'b1, word: 8'h8E, st: 8'h64};
        vecs[4] = '{sd: 8'hFF, gal: 1'b0, err: 1'b0, word: 8'hFF, st: 8'h0B};

        // Asynchronous reset: observed before any clock edge.
        #1 rst = 1'b1;
        #3;
        check("rst_state", state, 8'h01);
        check("rst_valid", out_valid, 1'b0);
        check("rst_data", out_data, 8'h00);
        check("rst_err", seed_err, 1'b0);
        tick();
        tick();
        rst       = 1'b0;
        out_ready = 1'b1;
        wait_valid(cyc);
        check("first_word_latency", cyc, 8);
        check("first_word_data", out_data, 8'h01);
        check("first_word_state", state, 8'h1C);
        tick();
        out_ready = 1'b0;

        foreach (vecs[i]) begin
            load_seed(vecs[i].sd, vecs[i].gal);
            exp_st = (vecs[i].sd == 8'h00) ? 8'h01 : vecs[i].sd;
            check($sformatf("vec%0d_err", i), seed_err, vecs[i].err);
            check($sformatf("vec%0d_load", i), state, exp_st);
            check($sformatf("vec%0d_valid0", i), out_valid, 1'b0);
            tick();
            check($sformatf("vec%0d_err_drop", i), seed_err, 1'b0);
            wait_valid(cyc);
            check($sformatf("vec%0d_latency", i), cyc, 7);
            check($sformatf("vec%0d_word", i), out_data, vecs[i].word);
            check($sformatf("vec%0d_state", i), state, vecs[i].st);
        end

        // First Galois step from seed 1.
        load_seed(8'h01, 1'b1);
        tick();
        check("gal_first_state", state, 8'hB8);
        check("gal_first_bit", out_data, 8'h01);

        // Period of both modes through the DUT, handshaking every word.
        for (int pm = 0; pm < 2; pm++) begin
            load_seed(8'h01, pm[0]);
            out_ready = 1'b1;
            prev  = 8'h01;
            steps = 0;
            bad   = 0;
            for (int c = 0; c < 1000; c++) begin
                tick();
                if (state != prev) begin
                    steps++;
                    m_s = m_next(m_s, m_gal);
                    if (state !== m_s || state == 8'h00) bad++;
                    prev = state;
                    if (state == 8'h01) break;
                end
            end
            out_ready = 1'b0;
            check($sformatf("period_mode%0d", pm), steps, 255);
            check($sformatf("trace_mode%0d", pm), bad, 0);
        end

        // Back-pressure: word and state hold for 20 cycles, then OUT_W+1 to the next word.
        load_seed(8'h3C, 1'b0);
        m_word(w);
        m_word(w2);
        wait_valid(cyc);
        check("hold_latency", cyc, 8);
        check("hold_word1", out_data, w);
        d_hold = out_data;
        s_hold = state;
        bad    = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (out_data !== d_hold || state !== s_hold || out_valid !== 1'b1) bad++;
        end
        check("hold_stable", bad, 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("hold_accept_valid", out_valid, 1'b0);
        wait_valid(cyc);
        check("hold_next_latency", cyc + 1, 9);
        check("hold_word2", out_data, w2);

        // Zero seed mid-fill discards the partial word.
        load_seed(8'h5A, 1'b0);
        for (int c = 0; c < 4; c++) tick();
        load_seed(8'h00, 1'b0);
        check("zero_mid_err", seed_err, 1'b1);
        check("zero_mid_state", state, 8'h01);
        check("zero_mid_valid", out_valid, 1'b0);
        tick();
        check("zero_mid_err_pulse", seed_err, 1'b0);
        wait_valid(cyc);
        check("zero_mid_latency", cyc, 7);
        check("zero_mid_word", out_data, 8'h01);
        check("zero_mid_state_end", state, 8'h1C);

        // seed_we wins over a handshake in HOLD.
        load_seed(8'hA5, 1'b0);
        wait_valid(cyc);
        out_ready = 1'b1;
        load_seed(8'h01, 1'b1);
        out_ready = 1'b0;
        check("seed_vs_ready_valid", out_valid, 1'b0);
        check("seed_vs_ready_state", state, 8'h01);
        wait_valid(cyc);
        check("seed_vs_ready_latency", cyc, 8);
        check("seed_vs_ready_word", out_data, 8'h8E);

        // Asynchronous reset mid-fill, also returning mode to Fibonacci.
        load_seed(8'hFF, 1'b1);
        for (int c = 0; c < 3; c++) tick();
        #3 rst = 1'b1;
        #1;
        check("rst_mid_state", state, 8'h01);
        check("rst_mid_valid", out_valid, 1'b0);
        check("rst_mid_data", out_data, 8'h00);
        check("rst_mid_err", seed_err, 1'b0);
        tick();
        rst = 1'b0;
        wait_valid(cyc);
        check("rst_mid_latency", cyc, 8);
        check("rst_mid_word", out_data, 8'h01);
        check("rst_mid_state_end", state, 8'h1C);

        // Randomized seeds, modes and ready patterns against the model.
        for (int r = 0; r < 12; r++) begin
            sd = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
            md = 1'($urandom_range(0, 1));
            load_seed(sd, md);
            bad = 0;
            if (seed_err !== (sd == 8'h00)) bad++;
            k = 0;
            for (int c = 0; c < 200 && k < 3; c++) begin
                out_ready = 1'($urandom_range(0, 1));
                if (out_valid && out_ready) begin
                    m_word(w);
                    if (out_data !== w) bad++;
                    k++;
                end
                tick();
            end
            out_ready = 1'b0;
            if (k < 3) bad++;
            check($sformatf("rand%0d_seed%0h_mode%0d", r, sd, md), bad, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/lfsr_stream.md
# lfsr_stream

Parametrised maximal-length LFSR generator with runtime Fibonacci/Galois selection, seed loading with all-zero rejection, and a valid/ready word output. Each word is built by stepping the LFSR once per cycle for OUT_W cycles, then held until consumed. It is the next-generation pseudo-random source for the design's test-pattern and dither consumers, replacing the fixed 8-bit single-bit-per-cycle generator.

## Interface

- WIDTH, 8, LFSR state width; supported 3..32, other values are an elaboration error
- OUT_W, 8, output word width; 1..WIDTH
- RESET_SEED, 1 (WIDTH bits), state after reset and substitute for a zero seed; must be non-zero
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- seed_we  in  1  load seed and mode this cycle
- seed  in  WIDTH  seed value
- mode  in  1  0 = Fibonacci, 1 = Galois; sampled only when seed_we = 1
- out_valid  out  1  out_data holds a complete word
- out_ready  in  1  consumer accepts word
- out_data  out  OUT_W  generated word
- state  out  WIDTH  current LFSR state
- seed_err  out  1  one-cycle pulse: zero seed was rejected

## Operation

- XOR feedback; all-zero is the lock-up state and is never entered.
- Fibonacci step: bit = s[WIDTH-1]; s' = {s[WIDTH-2:0], parity(s & TAPS)}.
- Galois step: bit = s[0]; s' = (s >> 1) ^ (s[0] ? TAPS : 0).
- TAPS from package table; WIDTH=8 → 8'hB8. Both modes have period 2^WIDTH-1.
- FSM, two states:
  - FILL: each cycle one step; out_data <= {out_data[OUT_W-2:0], bit}; cnt++. When cnt reaches OUT_W-1 on a step → HOLD, out_valid=1 next cycle.
  - HOLD: LFSR frozen, out_data stable. out_valid && out_ready → FILL, cnt=0, out_valid=0 next cycle.
- seed_we (any state, highest priority): state <= (seed==0 ? RESET_SEED : seed); mode_q <= mode; cnt=0; FSM → FILL; out_valid=0 next cycle; any partial or held word is discarded (even if out_ready=1 same cycle — no handshake occurs). seed==0 → seed_err=1 next cycle.
- Reset values: state=RESET_SEED, mode_q=0 (Fibonacci), FSM=FILL, cnt=0, out_data=0, out_valid=0, seed_err=0. Reset mid-word discards everything.
- out_data unchanged while out_valid=1 and not accepted; out_valid never drops without handshake, seed_we or rst.

## Timing

- First word: out_valid high on the OUT_W-th rising edge after rst deasserts (or after the seed_we edge).
- Throughput: one word per OUT_W+1 cycles at out_ready=1 (OUT_W fill + 1 handshake cycle).
- state output is the register, no combinational path from inputs. out_valid, out_data, seed_err are registered. No combinational ready→valid path.
- Seed takes effect on the edge where seed_we=1; first step from the new seed on the following edge.

## Structure

- lfsr_pkg: mode enum (LFSR_FIB, LFSR_GAL), function lfsr_taps(width) returning the maximal tap mask for 3..32, FSM state enum.
- Sub-module lfsr_step: combinational, params WIDTH/TAPS; inputs s, mode; outputs next state and out bit. Top holds registers, FSM, counter.

## Test plan

- Reset, WIDTH=8, OUT_W=8, out_ready=1 → out_valid rises 8 cycles after reset release, out_data=8'h01, state=8'h1C.
- seed_we with seed=8'h01, mode=1 → first Galois step gives state=8'hB8, bit=1; full word matches reference model.
- Period: Fibonacci and Galois from seed 1, count steps until state returns to 1 → exactly 255, state never 0.
- out_ready=0 for 20 cycles in HOLD → out_data, state stable, out_valid stays 1; then ready → next word after OUT_W+1 cycles.
- seed_we with seed=0 during FILL (cnt=4) → state=RESET_SEED, seed_err one-cycle pulse, cnt restarts, partial word discarded.
- seed_we and out_ready both high in HOLD → no word accepted, out_valid=0 next cycle; rst asserted mid-FILL → all outputs to reset values asynchronously.
